// File: rtl/cvp14_mem_seq_pkg.sv
// ============================================================================
// cvp14_pkg : shared encodings and widths for the CVP14 vector memory sequencer
// Revision  : 1.0
// ============================================================================
`default_nettype none

package cvp14_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;
    localparam int IDX_W      = 4;
    localparam int LEN_W      = 5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                   input logic [LEN_W-1:0] max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cvp14_mem_seq_lat_pipe.sv
// ============================================================================
// cvp14_lat_pipe : RD_LAT-deep {valid, idx} shift register tracking DRAM reads
// Revision       : 1.0
// ============================================================================
`default_nettype none

module cvp14_lat_pipe #(
    parameter int RD_LAT = 1,
    parameter int IDX_W  = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             vld_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic             vld_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             empty_o
);

    logic [RD_LAT-1:0]            vld_q;
    logic [RD_LAT-1:0][IDX_W-1:0] idx_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q <= '0;
            idx_q <= '0;
        end else begin
            vld_q[0] <= vld_i;
            idx_q[0] <= idx_i;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                idx_q[i] <= idx_q[i-1];
            end
        end
    end

    // "Empty" ignores the output stage: the read presented there is the last one owed.
    always_comb begin
        empty_o = 1'b1;
        for (int i = 0; i < RD_LAT - 1; i++) begin
            if (vld_q[i]) empty_o = 1'b0;
        end
    end

    assign vld_o = vld_q[RD_LAT-1];
    assign idx_o = idx_q[RD_LAT-1];

endmodule

`default_nettype wire

// File: rtl/cvp14_mem_seq.sv
// ============================================================================
// cvp14_mem_seq : vector load/store sequencer, one DRAM word access per cycle
// Optional      : CVP14_MEMSEQ_STRIDE_EN adds a Stride_i port (default unit stride)
// Revision      : 1.0
// ============================================================================
`default_nettype none

module cvp14_mem_seq
    import cvp14_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MAX_LEN = 16,
    parameter int RD_LAT  = 1
) (
    input  logic              Clk1_i,
    input  logic              Reset_i,
    input  logic              Start_i,
    input  logic              Write_i,
    input  logic [ADDR_W-1:0] BaseAddr_i,
    input  logic [LEN_W-1:0]  Len_i,
`ifdef CVP14_MEMSEQ_STRIDE_EN
    input  logic [ADDR_W-1:0] Stride_i,
`endif
    input  logic [DATA_W-1:0] EData_i,
    output logic [IDX_W-1:0]  ElemIdx_o,
    output logic              Busy_o,
    output logic              Done_o,
    output logic [ADDR_W-1:0] Addr_o,
    output logic              RD_o,
    output logic              WR_o,
    output logic [DATA_W-1:0] DataOut_o,
    input  logic [DATA_W-1:0] DataIn_i,
    output logic              RdValid_o,
    output logic [IDX_W-1:0]  RdIdx_o,
    output logic [DATA_W-1:0] RdData_o
);

    localparam logic [LEN_W-1:0] C_MAX_LEN = LEN_W'(MAX_LEN);

    state_t            state_q;
    logic              busy_q;
    logic              done_q;
    logic              rd_q;
    logic              wr_q;
    logic              write_q;
    logic              zwait_q;
    logic [ADDR_W-1:0] addr_q;
    logic [IDX_W-1:0]  idx_q;
    logic [LEN_W-1:0]  len_q;

    logic [LEN_W-1:0]  len_d;
    logic [ADDR_W-1:0] step;
    logic              last;
    logic              pipe_vld;
    logic [IDX_W-1:0]  pipe_idx;
    logic              pipe_empty;

    assign len_d = clamp_len(Len_i, C_MAX_LEN);
    assign last  = ({1'b0, idx_q} == (len_q - LEN_W'(1)));

`ifdef CVP14_MEMSEQ_STRIDE_EN
    logic [ADDR_W-1:0] stride_q;

    always_ff @(posedge Clk1_i or posedge Reset_i) begin
        if (Reset_i) begin
            stride_q <= '0;
        end else if (state_q == S_IDLE && Start_i) begin
            stride_q <= Stride_i;
        end
    end

    assign step = stride_q;
`else
    assign step = ADDR_W'(1);
`endif

    // Address advances by accumulation, so no multiplier is needed for the stride.
    always_ff @(posedge Clk1_i or posedge Reset_i) begin
        if (Reset_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            write_q <= 1'b0;
            zwait_q <= 1'b0;
            addr_q  <= '0;
            idx_q   <= '0;
            len_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (Start_i) begin
                        write_q <= Write_i;
                        len_q   <= len_d;
                        addr_q  <= BaseAddr_i;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        zwait_q <= 1'b0;
                        if (len_d == '0) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_ISSUE;
                            rd_q    <= ~Write_i;
                            wr_q    <= Write_i;
                        end
                    end
                end
                S_ISSUE: begin
                    if (last) begin
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        state_q <= write_q ? S_DONE : S_DRAIN;
                        done_q  <= write_q;
                    end else begin
                        idx_q  <= idx_q + IDX_W'(1);
                        addr_q <= addr_q + step;
                    end
                end
                S_DRAIN: begin
                    if (pipe_empty) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    // A zero-length request idles two cycles here before pulsing Done.
                    if (done_q) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (zwait_q) begin
                        done_q <= 1'b1;
                    end else begin
                        zwait_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    cvp14_lat_pipe #(
        .RD_LAT (RD_LAT),
        .IDX_W  (IDX_W)
    ) u_lat_pipe (
        .clk_i   (Clk1_i),
        .rst_i   (Reset_i),
        .vld_i   (rd_q),
        .idx_i   (idx_q),
        .vld_o   (pipe_vld),
        .idx_o   (pipe_idx),
        .empty_o (pipe_empty)
    );

    assign ElemIdx_o = idx_q;
    assign Busy_o    = busy_q;
    assign Done_o    = done_q;
    assign Addr_o    = addr_q;
    assign RD_o      = rd_q;
    assign WR_o      = wr_q;
    assign DataOut_o = EData_i;
    assign RdValid_o = pipe_vld;
    assign RdIdx_o   = pipe_idx;
    assign RdData_o  = pipe_vld ? DataIn_i : '0;

endmodule

`default_nettype wire

// File: tb/tb_cvp14_mem_seq.sv
// ============================================================================
// tb_cvp14_mem_seq : directed + random requests checked against a request-level model
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_cvp14_mem_seq;

`ifdef CVP14_MEMSEQ_STRIDE_EN
    localparam bit STRIDE_EN = 1'b1;
`else
    localparam bit STRIDE_EN = 1'b0;
`endif

    logic        Clk1 = 1'b0;
    logic        Reset, Start, Write;
    logic [15:0] BaseAddr, Stride, EData, DataOut, DataIn, Addr, RdData;
    logic [4:0]  Len;
    logic [3:0]  ElemIdx, RdIdx;
    logic        Busy, Done, RD, WR, RdValid;

    logic [15:0] dram    [0:65535];
    logic [15:0] ref_mem [0:65535];
    logic [15:0] vec     [0:15];

    int errors = 0;
    int checks = 0;

    always #5 Clk1 = ~Clk1;

    cvp14_mem_seq dut (
        .Clk1_i     (Clk1),
        .Reset_i    (Reset),
        .Start_i    (Start),
        .Write_i    (Write),
        .BaseAddr_i (BaseAddr),
        .Len_i      (Len),
`ifdef CVP14_MEMSEQ_STRIDE_EN
        .Stride_i   (Stride),
`endif
        .EData_i    (EData),
        .ElemIdx_o  (ElemIdx),
        .Busy_o     (Busy),
        .Done_o     (Done),
        .Addr_o     (Addr),
        .RD_o       (RD),
        .WR_o       (WR),
        .DataOut_o  (DataOut),
        .DataIn_i   (DataIn),
        .RdValid_o  (RdValid),
        .RdIdx_o    (RdIdx),
        .RdData_o   (RdData)
    );

    // Register-file side and single-cycle-latency DRAM environment
    assign EData = vec[ElemIdx];

    always @(posedge Clk1) begin
        if (WR) dram[Addr] = DataOut;
        DataIn <= RD ? dram[Addr] : 16'hDEAD;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, want);
        end
    endtask

    // Request-level model: n accesses at base+i*stride; load data returns one cycle
    // after each RD; Done one cycle after last WR / last return; Len=0 Done at 3rd sample.
    task automatic run_req(input logic wr, input logic [15:0] base, input logic [4:0] len,
                           input logic [15:0] stride, input bit spam);
        int          n;
        int          done_k;
        logic [15:0] eaddr[$];
        logic [15:0] edata[$];
        logic [15:0] a;
        logic [15:0] st;
        bit          exp_rv;

        st = STRIDE_EN ? stride : 16'd1;
        n  = (len > 5'd16) ? 16 : int'(len);
        for (int i = 0; i < n; i++) begin
            a = base + 16'(i) * st;
            eaddr.push_back(a);
            if (wr) ref_mem[a] = vec[i];
            else    edata.push_back(ref_mem[a]);
        end
        done_k = (n == 0) ? 3 : (wr ? n + 1 : n + 2);

        @(negedge Clk1);
        Start = 1'b1; Write = wr; BaseAddr = base; Len = len; Stride = stride;
        for (int k = 1; k <= done_k + 1; k++) begin
            @(negedge Clk1);
            chk($sformatf("RD k=%0d", k), 32'(RD), 32'(k <= n && !wr));
            chk($sformatf("WR k=%0d", k), 32'(WR), 32'(k <= n && wr));
            if (k <= n) begin
                chk($sformatf("Addr k=%0d", k), 32'(Addr), 32'(eaddr[k-1]));
                chk($sformatf("ElemIdx k=%0d", k), 32'(ElemIdx), 32'(k - 1));
            end
            exp_rv = !wr && k >= 2 && k <= n + 1;
            chk($sformatf("RdValid k=%0d", k), 32'(RdValid), 32'(exp_rv));
            if (exp_rv) begin
                chk($sformatf("RdIdx k=%0d", k), 32'(RdIdx), 32'(k - 2));
                chk($sformatf("RdData k=%0d", k), 32'(RdData), 32'(edata[k-2]));
            end
            chk($sformatf("Done k=%0d", k), 32'(Done), 32'(k == done_k));
            chk($sformatf("Busy k=%0d", k), 32'(Busy), 32'(k <= done_k));
            Start    = spam && (k < done_k);
            Write    = 1'($urandom);
            BaseAddr = 16'($urandom);
            Len      = 5'($urandom);
            Stride   = 16'($urandom);
        end
        Start = 1'b0;
        if (wr) begin
            foreach (eaddr[i]) chk($sformatf("dram[%h]", eaddr[i]), 32'(dram[eaddr[i]]),
                                   32'(ref_mem[eaddr[i]]));
        end
    endtask

    task automatic fill_vec_random();
        for (int i = 0; i < 16; i++) vec[i] = 16'($urandom);
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Write = 1'b0; BaseAddr = '0; Len = '0; Stride = 16'd1;
        for (int i = 0; i < 65536; i++) begin
            dram[i]    = 16'($urandom);
            ref_mem[i] = dram[i];
        end
        fill_vec_random();
        repeat (2) @(negedge Clk1);
        chk("rst Busy", 32'(Busy), 0);
        chk("rst Done", 32'(Done), 0);
        chk("rst RD", 32'(RD), 0);
        chk("rst WR", 32'(WR), 0);
        chk("rst RdValid", 32'(RdValid), 0);
        chk("rst Addr", 32'(Addr), 0);
        chk("rst ElemIdx", 32'(ElemIdx), 0);
        chk("rst RdIdx", 32'(RdIdx), 0);
        Reset = 1'b0;

        // Load of four known words
        for (int i = 0; i < 4; i++) begin
            dram[16'h0010 + i]    = 16'hA0A0 + 16'(i);
            ref_mem[16'h0010 + i] = 16'hA0A0 + 16'(i);
        end
        run_req(1'b0, 16'h0010, 5'd4, 16'd1, 1'b0);

        // Full-length store of 0x5000+idx
        for (int i = 0; i < 16; i++) vec[i] = 16'h5000 + 16'(i);
        run_req(1'b1, 16'h0100, 5'd16, 16'd1, 1'b0);

        // Address wrap and length clamp
        run_req(1'b0, 16'hFFFE, 5'd4, 16'd1, 1'b0);
        run_req(1'b0, 16'($urandom), 5'd20, 16'd1, 1'b0);

        // Zero length, and Start held high throughout busy requests
        run_req(1'b0, 16'h0500, 5'd0, 16'd1, 1'b0);
        fill_vec_random();
        run_req(1'b1, 16'h0200, 5'd3, 16'd1, 1'b1);
        run_req(1'b0, 16'h0300, 5'd0, 16'd1, 1'b1);

        // Asynchronous reset in the middle of a load
        @(negedge Clk1);
        Start = 1'b1; Write = 1'b0; BaseAddr = 16'h0400; Len = 5'd8;
        @(negedge Clk1);
        Start = 1'b0;
        @(negedge Clk1);
        chk("mid RD before rst", 32'(RD), 1);
        chk("mid RdValid before rst", 32'(RdValid), 1);
        Reset = 1'b1;
        #1;
        chk("mid rst RD", 32'(RD), 0);
        chk("mid rst RdValid", 32'(RdValid), 0);
        chk("mid rst Busy", 32'(Busy), 0);
        chk("mid rst Addr", 32'(Addr), 0);
        @(negedge Clk1);
        Reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge Clk1);
            chk($sformatf("post rst Done c=%0d", k), 32'(Done), 0);
            chk($sformatf("post rst RD c=%0d", k), 32'(RD), 0);
            chk($sformatf("post rst RdValid c=%0d", k), 32'(RdValid), 0);
            chk($sformatf("post rst Busy c=%0d", k), 32'(Busy), 0);
        end
        run_req(1'b0, 16'h0400, 5'd2, 16'd1, 1'b0);

        if (STRIDE_EN) begin
            fill_vec_random();
            run_req(1'b1, 16'h0020, 5'd3, 16'd3, 1'b0);
            run_req(1'b1, 16'h0020, 5'd3, 16'd0, 1'b0);
            run_req(1'b0, 16'h0020, 5'd4, 16'd0, 1'b0);
        end

        // Random requests
        for (int r = 0; r < 30; r++) begin
            fill_vec_random();
            run_req(1'($urandom), 16'($urandom), 5'($urandom),
                    16'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
